// File: rtl/exc_pkg.sv
// exc_pkg: shared states, cause codes, vectors and PC-select codes for exception_ctrl.
// Defining EXC_DIV0_EN makes divide-by-zero an exception source.
package exc_pkg;
    typedef enum logic [2:0] {IDLE, SAVE, READ, WAIT, LOAD, RET} state_t;
    typedef enum logic [1:0] {C_NONE = 2'b00, C_INV = 2'b01, C_OVF = 2'b10, C_DIV0 = 2'b11} cause_t;
    localparam logic [7:0] VEC_INV  = 8'hFD;
    localparam logic [7:0] VEC_OVF  = 8'hFE;
    localparam logic [7:0] VEC_DIV0 = 8'hFF;
    localparam logic [2:0] SEL_ALU = 3'b000;
    localparam logic [2:0] SEL_MEM = 3'b010;
    localparam logic [2:0] SEL_EPC = 3'b100;
`ifdef EXC_DIV0_EN
    localparam logic DIV0_EN = 1'b1;
`else
    localparam logic DIV0_EN = 1'b0;
`endif
    function automatic logic [7:0] vector(input cause_t c);
        return c == C_INV ? VEC_INV : c == C_OVF ? VEC_OVF : VEC_DIV0;
    endfunction
endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: fixed-priority encoder of exception sources, inv_op > ovf > div0.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic   inv_op,
    input  logic   ovf,
    input  logic   div0,
    output logic   valid,
    output cause_t cause
);
    assign valid = inv_op | ovf | div0;
    assign cause = inv_op ? C_INV : ovf ? C_OVF : div0 ? C_DIV0 : C_NONE;
endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl: Moore FSM that saves EPC, fetches the handler vector and drives the PC mux.
// Divide-by-zero is honoured only when EXC_DIV0_EN is defined.
module exception_ctrl
    import exc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_check,
    input  logic        inv_op,
    input  logic        ovf,
    input  logic        div0,
    input  logic        eret,
    input  logic [31:0] pc_in,
    input  logic [7:0]  mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic [2:0]  pc_sel,
    output logic        pc_wr,
    output logic        busy
);
    state_t state, next;
    cause_t cause_q, enc_cause;
    logic   enc_valid;
    logic   unused_ok;

    exc_prio_enc u_enc (
        .inv_op (inv_op),
        .ovf    (ovf),
        .div0   (div0 & DIV0_EN),
        .valid  (enc_valid),
        .cause  (enc_cause)
    );

    // mem_rdata feeds the external PC mux directly; this block only selects it
    assign unused_ok = ^mem_rdata;
    assign cause     = cause_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            epc     <= '0;
            cause_q <= C_NONE;
        end else begin
            state <= next;
            if (state == IDLE && next == SAVE) cause_q <= enc_cause;
            if (state == SAVE) epc <= pc_in - 32'd4;
        end
    end

    always_comb begin
        next     = IDLE;
        mem_rd   = 1'b0;
        mem_addr = '0;
        pc_sel   = SEL_ALU;
        pc_wr    = 1'b0;
        busy     = state != IDLE;
        case (state)
            IDLE: next = exc_check && enc_valid ? SAVE : eret ? RET : IDLE;
            SAVE: next = READ;
            READ, WAIT: begin
                next     = state == READ ? WAIT : LOAD;
                mem_rd   = 1'b1;
                mem_addr = {24'b0, vector(cause_q)};
            end
            LOAD: begin
                pc_sel = SEL_MEM;
                pc_wr  = 1'b1;
            end
            RET: begin
                pc_sel = SEL_EPC;
                pc_wr  = 1'b1;
            end
            default: next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl: directed and randomized checks of exception_ctrl against a cycle-schedule model.
module tb_exception_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0, exc_check = 1'b0, inv_op = 1'b0, ovf = 1'b0, div0 = 1'b0, eret = 1'b0;
    logic [31:0] pc_in = '0;
    logic [7:0]  mem_rdata = '0;
    logic [31:0] mem_addr, epc;
    logic        mem_rd, pc_wr, busy;
    logic [1:0]  cause;
    logic [2:0]  pc_sel;
    int          checks = 0, errors = 0;
    logic [31:0] pc_val = 32'h104;

`ifdef EXC_DIV0_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    typedef struct packed {
        bit          busy;
        bit          rd;
        bit          wr;
        bit          save;
        logic [31:0] addr;
        logic [2:0]  sel;
    } exp_t;

    exp_t        sched[$];
    logic [31:0] m_epc = '0;
    logic [1:0]  m_cause = '0;

    exception_ctrl dut (
        .clk(clk), .reset(reset), .exc_check(exc_check), .inv_op(inv_op), .ovf(ovf),
        .div0(div0), .eret(eret), .pc_in(pc_in), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .epc(epc), .cause(cause),
        .pc_sel(pc_sel), .pc_wr(pc_wr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(bit b, bit rd, bit wr, bit sv, logic [31:0] a, logic [2:0] s);
        exp_t e;
        e.busy = b; e.rd = rd; e.wr = wr; e.save = sv; e.addr = a; e.sel = s;
        return e;
    endfunction

    // One clock: drive on the falling edge, advance the model on the rising edge, compare 1 ns later.
    task automatic step(input bit r, input bit c, input bit io, input bit ov, input bit dz, input bit er);
        exp_t        e;
        logic [31:0] v;
        @(negedge clk);
        reset = r; exc_check = c; inv_op = io; ovf = ov; div0 = dz; eret = er;
        pc_in = pc_val; mem_rdata = 8'($urandom);
        @(posedge clk);
        if (!r) begin
            sched.delete();
            m_epc = '0;
            m_cause = '0;
        end else if (sched.size() != 0) begin
            if (sched[0].save) m_epc = pc_val - 32'd4;
            void'(sched.pop_front());
        end else if (c && (io || ov || (DZ_EN && dz))) begin
            m_cause = io ? 2'd1 : ov ? 2'd2 : 2'd3;
            v = 32'hFC + 32'(m_cause);
            sched.push_back(mk(1, 0, 0, 1, 0, 3'b000));
            sched.push_back(mk(1, 1, 0, 0, v, 3'b000));
            sched.push_back(mk(1, 1, 0, 0, v, 3'b000));
            sched.push_back(mk(1, 0, 1, 0, 0, 3'b010));
        end else if (er) begin
            sched.push_back(mk(1, 0, 1, 0, 0, 3'b100));
        end
        e = sched.size() != 0 ? sched[0] : '0;
        #1;
        check("busy", busy, e.busy);
        check("mem_rd", mem_rd, e.rd);
        check("pc_wr", pc_wr, e.wr);
        check("pc_sel", pc_sel, e.sel);
        check("mem_addr", mem_addr, e.addr);
        check("epc", epc, m_epc);
        check("cause", cause, m_cause);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 1);
        check("rst_epc", epc, 32'h0);
        check("rst_busy", busy, 1'b0);
        // invalid opcode with pc_in = 0x104
        step(1, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("inv_epc", epc, 32'h100);
        check("inv_cause", cause, 2'b01);
        check("inv_addr1", mem_addr, 32'hFD);
        step(1, 1, 1, 1, 1, 1);
        check("inv_addr2", mem_addr, 32'hFD);
        check("inv_rd2", mem_rd, 1'b1);
        step(1, 0, 0, 0, 0, 1);
        check("inv_sel4", pc_sel, 3'b010);
        check("inv_wr4", pc_wr, 1'b1);
        step(1, 0, 0, 0, 0, 0);
        check("inv_idle", busy, 1'b0);
        // ovf beats div0
        step(1, 1, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        check("prio_cause", cause, 2'b10);
        check("prio_addr", mem_addr, 32'hFE);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // exception and eret together: exception wins, eret dropped
        step(1, 1, 0, 1, 0, 1);
        check("both_busy", busy, 1'b1);
        check("both_nowr", pc_wr, 1'b0);
        repeat (3) step(1, 0, 0, 0, 0, 0);
        check("both_sel", pc_sel, 3'b010);
        step(1, 0, 0, 0, 0, 0);
        check("both_noret", pc_wr, 1'b0);
        // eret with epc = 0x100
        step(1, 0, 0, 0, 0, 1);
        check("ret_epc", epc, 32'h100);
        check("ret_sel", pc_sel, 3'b100);
        check("ret_wr", pc_wr, 1'b1);
        step(1, 0, 0, 0, 0, 0);
        check("ret_sel0", pc_sel, 3'b000);
        check("ret_wr0", pc_wr, 1'b0);
        // reset while in WAIT
        step(1, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("mid_rd", mem_rd, 1'b1);
        step(0, 0, 0, 0, 0, 0);
        check("mid_busy", busy, 1'b0);
        check("mid_epc", epc, 32'h0);
        step(1, 0, 0, 0, 0, 0);
        check("mid_nowr", pc_wr, 1'b0);
        // div0 alone
        step(1, 1, 0, 0, 1, 0);
        check("dz_busy", busy, DZ_EN);
        repeat (4) step(1, 0, 0, 0, 0, 0);
        check("dz_cause", cause, DZ_EN ? 2'b11 : 2'b00);
        for (int i = 0; i < 3000; i++) begin
            pc_val = $urandom;
            step($urandom_range(0, 39) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous reset, active-low (0 = reset).
REQ-004 exc_check  input  1  strobe from main control; exception sources are sampled only when this is high.
REQ-005 inv_op  input  1  invalid opcode.
REQ-006 ovf  input  1  ALU overflow.
REQ-007 div0  input  1  divide by zero.
REQ-008 eret  input  1  return-from-exception request.
REQ-009 pc_in  input  32  current PC, already incremented by 4.
REQ-010 mem_rdata  input  8  byte returned by memory.
REQ-011 mem_addr  output  32  vector address.
REQ-012 mem_rd  output  1  memory read enable.
REQ-013 epc  output  32  saved exception PC; feeds the PC-source mux epc input.
REQ-014 cause  output  2  last cause: 01 inv_op, 10 ovf, 11 div0, 00 none.
REQ-015 pc_sel  output  3  PC-source mux select: 000 ALU result, 010 memory data extended, 100 EPC.
REQ-016 pc_wr  output  1  PC write enable.
REQ-017 busy  output  1  high in every state except IDLE; main control stalls while it is high.

Function
REQ-018 The FSM SHALL have the states IDLE, SAVE, READ, WAIT, LOAD and RET, and SHALL be a Moore machine: every output except epc and cause is decoded from the state only.
REQ-019 In IDLE, when exc_check=1 and any source is set, the next state SHALL be SAVE.
REQ-020 Cause priority SHALL be inv_op > ovf > div0, and the winning cause SHALL be latched into cause on that same edge.
REQ-021 In SAVE: epc <= pc_in - 4 (32-bit, wraps modulo 2^32); next state READ.
REQ-022 In READ and WAIT:
  - mem_rd=1.
  - mem_addr = vector: 0x000000FD for inv_op, 0x000000FE for ovf, 0x000000FF for div0.
  - READ goes to WAIT; WAIT goes to LOAD.
REQ-023 In LOAD: pc_sel=010 and pc_wr=1; the PC loads {24'b0, mem_rdata}; next state IDLE.
REQ-024 In IDLE, when eret=1 and no exception is being taken, the next state SHALL be RET.
REQ-025 In RET: pc_sel=100 and pc_wr=1 for exactly one cycle; next state IDLE.
REQ-026 If exc_check with a source set and eret arrive in the same cycle, the exception SHALL win and eret SHALL be dropped.
REQ-027 Any source, exc_check or eret asserted while busy=1 SHALL be ignored (no queuing).
REQ-028 Outside the active states: pc_sel=000, pc_wr=0, mem_rd=0, mem_addr=0.
REQ-029 Exception latency: exactly 4 cycles from the sampling edge to the handler PC write; eret latency: 1 cycle.
REQ-030 epc and cause SHALL hold their values until the next exception.

Reset
REQ-031 reset=0 at a clock edge SHALL force IDLE and clear epc, cause, pc_sel, pc_wr, mem_rd, mem_addr and busy to 0.
REQ-032 A reset in any state, including mid-sequence, SHALL abort the sequence with no PC write on the following cycle.

Configuration
REQ-033 The macro EXC_DIV0_EN SHALL control the divide-by-zero source:
  - defined: div0 is a valid source with vector 0xFF.
  - undefined: the div0 port remains but is ignored, and cause never reads 11.

Structure
REQ-034 A shared package exc_pkg SHALL hold:
  - the state enum;
  - the cause codes;
  - the vector constants 0xFD, 0xFE and 0xFF;
  - the pc_sel codes SEL_ALU=000, SEL_MEM=010 and SEL_EPC=100.
REQ-035 The priority encoder SHALL be a sub-module named exc_prio_enc (inputs inv_op, ovf, div0; outputs valid and cause).

Verification
REQ-036 Invalid opcode: exc_check=1, inv_op=1, pc_in=0x00000104.
  - Required: epc=0x00000100 and cause=01.
  - mem_addr=0xFD with mem_rd=1 for 2 cycles.
  - With mem_rdata=0x80: pc_sel=010 and pc_wr=1 in cycle 4.
REQ-037 Priority: ovf=1 and div0=1 together -> cause=10, mem_addr=0xFE.
REQ-038 Simultaneous eret=1 and exc_check=1 with ovf=1 -> exception sequence runs, no RET cycle.
REQ-039 eret in IDLE with epc=0x00000100 -> one cycle of pc_sel=100 and pc_wr=1, then pc_sel=000.
REQ-040 Reset mid-sequence: reset=0 in WAIT -> next cycle IDLE, all outputs 0, no pc_wr.
REQ-041 EXC_DIV0_EN undefined, div0=1 with exc_check=1 -> stays IDLE, busy=0.
